// File: rtl/mux4_scan_sequencer.sv
// Scan sequencer driving a 4:1 mux: latches a word, steps s with a dwell, reassembles y.
// Optional loopback comparator enabled by defining LOOPBACK_CHECK_EN.
module mux4_scan_sequencer #(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       abort,
    output logic [3:0] w,
    output logic [1:0] s,
    input  logic       y,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       mismatch
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    w_q, w_d;
    logic [1:0]    s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cap_q, cap_d;
    logic          mis_q, mis_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        mis_d   = mis_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    w_d     = in_data;
                    s_d     = '0;
                    cnt_d   = '0;
                    cap_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                    s_d     = '0;
                    cnt_d   = '0;
                    cap_d   = '0;
                end else if (cnt_q == LAST) begin
                    cnt_d      = '0;
                    cap_d[s_q] = y;
                    if (s_q == 2'd3) begin
                        state_d = DONE;
`ifdef LOOPBACK_CHECK_EN
                        mis_d = ({y, cap_q[2:0]} != w_q);
`endif
                    end else begin
                        s_d = s_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // abort and accept lead to the same end state
                if (abort || out_ready) begin
                    state_d = IDLE;
                    s_d     = '0;
                    cap_d   = '0;
                    mis_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
                cnt_d   = '0;
                cap_d   = '0;
                mis_d   = 1'b0;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SCAN);
    assign out_valid = (state_q == DONE);
    assign out_data  = cap_q;
    assign w         = w_q;
    assign s         = s_q;

`ifdef LOOPBACK_CHECK_EN
    assign mismatch = mis_q;
`else
    assign mismatch = 1'b0;
    logic unused_mis;
    assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Directed bench for mux4_scan_sequencer with a behavioural 4:1 mux on the loop.
// Expected mismatch in the forced-y test follows LOOPBACK_CHECK_EN.
module tb_mux4_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       abort;
    logic [3:0] w;
    logic [1:0] s;
    logic       y;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       mismatch;
    logic       yforce;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign y = yforce ? 1'b0 : w[s];

    mux4_scan_sequencer #(.DWELL(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .w         (w),
        .s         (s),
        .y         (y),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mismatch  (mismatch)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, {7'd0, in_ready}, 8'd1);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_ov"}, {7'd0, out_valid}, 8'd0);
        chk({tag, "_od"}, {4'd0, out_data}, 8'd0);
        chk({tag, "_mis"}, {7'd0, mismatch}, 8'd0);
        chk({tag, "_s"}, {6'd0, s}, 8'd0);
        chk({tag, "_w"}, {4'd0, w}, 8'd0);
    endtask

    // accept word at next edge, then run 8 edges to DONE
    task automatic scan_word(input logic [3:0] d, input string tag);
        in_valid = 1'b1;
        in_data  = d;
        step();
        chk({tag, "_acc"}, {7'd0, busy}, 8'd1);
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) step();
        chk({tag, "_ov"}, {7'd0, out_valid}, 8'd1);
    endtask

    logic exp_mis5;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        abort     = 1'b0;
        out_ready = 1'b0;
        yforce    = 1'b0;
`ifdef LOOPBACK_CHECK_EN
        exp_mis5 = 1'b1;
`else
        exp_mis5 = 1'b0;
`endif

        // 1: reset
        step();
        step();
        chk_reset("rst1");
        rst = 1'b0;
        step();
        chk_reset("idle");

        // 2: 1010 scan, s trace, hold
        in_valid = 1'b1;
        in_data  = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            step();
            in_valid = 1'b0;
            in_data  = 4'b0101;
            chk($sformatf("t2_s%0d", k), {6'd0, s}, 8'(k / 2));
            chk($sformatf("t2_ov%0d", k), {7'd0, out_valid}, 8'd0);
        end
        chk("t2_w", {4'd0, w}, 8'hA);
        step();
        chk("t2_ov", {7'd0, out_valid}, 8'd1);
        chk("t2_od", {4'd0, out_data}, 8'hA);
        chk("t2_mis", {7'd0, mismatch}, 8'd0);
        chk("t2_sdone", {6'd0, s}, 8'd3);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("t2_hold%0d", k), {4'd0, out_data}, 8'hA);
            chk($sformatf("t2_hov%0d", k), {7'd0, out_valid}, 8'd1);
        end
        out_ready = 1'b1;
        step();
        chk("t2_rel_ov", {7'd0, out_valid}, 8'd0);
        chk("t2_rel_rdy", {7'd0, in_ready}, 8'd1);
        chk("t2_rel_s", {6'd0, s}, 8'd0);

        // 3: back-to-back, in_valid held high
        in_valid = 1'b1;
        in_data  = 4'b0001;
        step();
        chk("t3_acc1", {7'd0, busy}, 8'd1);
        in_data = 4'b1111;
        for (int k = 0; k < 8; k++) step();
        chk("t3_ov1", {7'd0, out_valid}, 8'd1);
        chk("t3_od1", {4'd0, out_data}, 8'h1);
        step();
        chk("t3_bubble", {7'd0, in_ready}, 8'd1);
        chk("t3_bubble_busy", {7'd0, busy}, 8'd0);
        step();
        chk("t3_acc2", {7'd0, busy}, 8'd1);
        chk("t3_w2", {4'd0, w}, 8'hF);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) step();
        chk("t3_ov2", {7'd0, out_valid}, 8'd1);
        chk("t3_od2", {4'd0, out_data}, 8'hF);
        step();
        chk("t3_done2", {7'd0, in_ready}, 8'd1);

        // 4: abort at T0+3
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'b0110;
        step();
        in_valid = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_rdy", {7'd0, in_ready}, 8'd1);
        chk("t4_s", {6'd0, s}, 8'd0);
        chk("t4_ov", {7'd0, out_valid}, 8'd0);
        chk("t4_w", {4'd0, w}, 8'h6);
        for (int k = 0; k < 6; k++) step();
        chk("t4_noov", {7'd0, out_valid}, 8'd0);
        // abort together with in_valid in IDLE: accepted
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'b0101;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("t4_acc", {7'd0, busy}, 8'd1);
        for (int k = 0; k < 8; k++) step();
        chk("t4_ov2", {7'd0, out_valid}, 8'd1);
        chk("t4_od2", {4'd0, out_data}, 8'h5);
        // abort and out_ready together in DONE
        abort     = 1'b1;
        out_ready = 1'b1;
        step();
        abort     = 1'b0;
        out_ready = 1'b0;
        chk("t4_abdone_ov", {7'd0, out_valid}, 8'd0);
        chk("t4_abdone_rdy", {7'd0, in_ready}, 8'd1);
        chk("t4_abdone_s", {6'd0, s}, 8'd0);

        // 5: y forced low
        yforce = 1'b1;
        scan_word(4'b1000, "t5");
        chk("t5_od", {4'd0, out_data}, 8'h0);
        chk("t5_mis", {7'd0, mismatch}, {7'd0, exp_mis5});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t5_mis_clr", {7'd0, mismatch}, 8'd0);
        yforce = 1'b0;

        // 6: reset mid-scan and in DONE
        in_valid = 1'b1;
        in_data  = 4'b1100;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("t6_s2", {6'd0, s}, 8'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset("t6_scan");
        scan_word(4'b0011, "t6b");
        chk("t6_od", {4'd0, out_data}, 8'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset("t6_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
